multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle control FSM for the processor datapath, replacing single-cycle opcode decode when instruction and data memory share one port.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, waiting on the memory ready handshake.
- Drives datapath mux selects and write enables, including the swap, jr, jal and sll extensions.

Parameters:
COUNT_W, 32, width of retired-instruction counter (used only with optional feature)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opCode  input  6  IR[31:26], stable from DECODE until instruction end
zero  input  1  ALU zero flag (datapath gates it with PCWriteCond)
mem_ready  input  1  memory access complete this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if zero
IorD  output  1  0=PC address, 1=ALUOut address
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
RegDst  output  2  00 rt, 01 rd, 10 $31, 11 rs
MemtoReg  output  2  00 ALUOut, 01 MDR, 10 PC, 11 swap data
RegWrite  output  1  register file write
ALUSrcA  output  1  0 PC, 1 A
ALUSrcB  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
ALUOp  output  2  00 add, 01 sub, 10 funct
PCSource  output  2  00 ALU, 01 ALUOut, 10 jump target, 11 A
Shift  output  1  ALU performs sll
SwapPhase  output  1  swap data select: 0=A, 1=B
instr_done  output  1  one-cycle pulse on last cycle of each instruction
state  output  4  current state, debug

Behaviour:
- States (4-bit encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, JR 10, JAL 11, ADDIEX 12, ADDIWB 13, SWAP1 14, SWAP2 15.
- Reset: state<=FETCH on the next edge. While reset is high, every output is 0 (state reads 0).
- Outputs are decoded from state; any output not listed for a state is 0.
- FETCH: MemRead=1, ALUSrcB=01.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUSrcB=11. Next state by opCode:
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 010000 -> JR
  - 000011 -> JAL
  - 001000 -> ADDIEX
  - 111111 -> SWAP1
  - all others, including 000001 (sll) and R-type -> EXEC
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next is MEMRD if opCode=100011, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready.
- EXEC: ALUSrcA=1, ALUOp=10, Shift=(opCode==000001). Next is ALUWB.
- ALUWB: RegWrite=1, RegDst=01.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Next is ADDIWB.
- ADDIWB: RegWrite=1, RegDst=00.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
- JUMP: PCWrite=1, PCSource=10.
- JR: PCWrite=1, PCSource=11.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. PC still holds PC+4 at this point.
- SWAP1: RegWrite=1, RegDst=00, MemtoReg=11, SwapPhase=0 (rt<-A). Next is SWAP2.
- SWAP2: RegWrite=1, RegDst=11, MemtoReg=11, SwapPhase=1 (rs<-B).
- Return to FETCH from: MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, JR, JAL, SWAP2, and from MEMWR on mem_ready. instr_done=1 in exactly that cycle.
- Latency with mem_ready held at 1:
  - lw: 5 cycles
  - sw, R-type, sll, addi, swap: 4 cycles
  - beq, j, jr, jal: 3 cycles
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- A wait has no timeout; the FSM holds, with outputs stable, indefinitely.
- Reset asserted mid-instruction: the in-flight access is abandoned, no instr_done pulse is produced, and the next state is FETCH.

Optional Feature:
CTRL_INSTR_COUNT_EN
- Defined: adds output port instr_count [COUNT_W-1:0].
  - Cleared to 0 by reset.
  - Increments by 1 on every cycle with instr_done=1.
  - Wraps from all-ones to 0.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles, mem_ready=1, opCode=000000 -> all outputs 0 during reset; afterwards state sequence 0,1,6,7,0; RegDst=01 and RegWrite=1 in state 7; instr_done pulses once.
- opCode=100011, mem_ready low for 3 cycles in FETCH and 2 cycles in MEMRD -> FETCH lasts 4 cycles with IRWrite only in its last cycle; MEMRD lasts 3 cycles; then MEMWB with MemtoReg=01; total 10 cycles.
- opCode=101011, mem_ready=1 -> states 0,1,2,5,0; MemWrite=1 and IorD=1 in state 5; RegWrite never asserted.
- opCode=000100, then 000011, then 111111 -> beq: state 8 with PCWriteCond=1, PCSource=01; jal: state 11 with RegDst=10, MemtoReg=10, PCWrite=1; swap: states 14,15 with SwapPhase 0 then 1, RegDst 00 then 11.
- opCode=000001 -> EXEC has Shift=1, ALUOp=10; opCode=001000 -> states 12,13 with ALUSrcB=10, RegDst=00.
- Reset asserted while in MEMRD waiting on mem_ready -> MemRead=0 during reset; state=0 the next cycle; no instr_done; with CTRL_INSTR_COUNT_EN, instr_count=0 and then 9 after nine completed instructions.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback over a shared memory port.
// Optional retired-instruction counter enabled by defining CTRL_INSTR_COUNT_EN.
module multicycle_control #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opCode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Shift,
    output logic       SwapPhase,
    output logic       instr_done,
    output logic [3:0] state
`ifdef CTRL_INSTR_COUNT_EN
    ,
    output logic [COUNT_W-1:0] instr_count
`endif
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        JR     = 4'd10,
        JAL    = 4'd11,
        ADDIEX = 4'd12,
        ADDIWB = 4'd13,
        SWAP1  = 4'd14,
        SWAP2  = 4'd15
    } state_t;

    state_t st_q, st_d;

    // The zero flag is combined with PCWriteCond in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk) begin
        if (reset) st_q <= FETCH;
        else       st_q <= st_d;
    end

    // Outputs are forced low while reset is high, whatever state the register holds.
    assign state = reset ? '0 : st_q;

    always_comb begin
        st_d        = st_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = '0;
        MemtoReg    = '0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = '0;
        ALUOp       = '0;
        PCSource    = '0;
        Shift       = 1'b0;
        SwapPhase   = 1'b0;
        instr_done  = 1'b0;
        if (!reset) begin
            unique case (st_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    if (mem_ready) st_d = DECODE;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    case (opCode)
                        6'b100011, 6'b101011: st_d = MEMADR;
                        6'b000100:            st_d = BRANCH;
                        6'b000010:            st_d = JUMP;
                        6'b010000:            st_d = JR;
                        6'b000011:            st_d = JAL;
                        6'b001000:            st_d = ADDIEX;
                        6'b111111:            st_d = SWAP1;
                        default:              st_d = EXEC;
                    endcase
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    st_d    = (opCode == 6'b100011) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    if (mem_ready) st_d = MEMWB;
                end
                MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 2'b01;
                    instr_done = 1'b1;
                    st_d       = FETCH;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        st_d       = FETCH;
                    end
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                    Shift   = (opCode == 6'b000001);
                    st_d    = ALUWB;
                end
                ALUWB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 2'b01;
                    instr_done = 1'b1;
                    st_d       = FETCH;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    instr_done  = 1'b1;
                    st_d        = FETCH;
                end
                JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                    st_d       = FETCH;
                end
                JR: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b11;
                    instr_done = 1'b1;
                    st_d       = FETCH;
                end
                JAL: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    RegWrite   = 1'b1;
                    RegDst     = 2'b10;
                    MemtoReg   = 2'b10;
                    instr_done = 1'b1;
                    st_d       = FETCH;
                end
                ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    st_d    = ADDIWB;
                end
                ADDIWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    st_d       = FETCH;
                end
                SWAP1: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b11;
                    st_d     = SWAP2;
                end
                SWAP2: begin
                    RegWrite   = 1'b1;
                    RegDst     = 2'b11;
                    MemtoReg   = 2'b11;
                    SwapPhase  = 1'b1;
                    instr_done = 1'b1;
                    st_d       = FETCH;
                end
            endcase
        end
    end

`ifdef CTRL_INSTR_COUNT_EN
    logic [COUNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset)           cnt_q <= '0;
        else if (instr_done) cnt_q <= cnt_q + COUNT_W'(1);
    end

    assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: driver pushes per-cycle expectations from a
// phase-list model of each instruction; monitor pops and compares every cycle.
module tb_multicycle_control;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic [1:0] RegDst;
        logic [1:0] MemtoReg;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic [1:0] PCSource;
        logic       Shift;
        logic       SwapPhase;
        logic       instr_done;
        logic [3:0] state;
    } out_t;

    typedef struct packed {
        logic rst;
        out_t e;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opCode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic       ALUSrcA, Shift, SwapPhase, instr_done;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
`ifdef CTRL_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    multicycle_control #(.COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .opCode(opCode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .Shift(Shift), .SwapPhase(SwapPhase),
        .instr_done(instr_done), .state(state)
`ifdef CTRL_INSTR_COUNT_EN
        , .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    ent_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_done = 0;
    int   seen_done = 0;
    bit   mon_stop = 1'b0;

    // Per-state output table taken directly from the state descriptions.
    function automatic out_t expect_out(int st, bit mr, bit [5:0] op, bit last);
        out_t e = '0;
        e.state      = 4'(st);
        e.instr_done = last;
        case (st)
            0:  begin e.MemRead = 1; e.ALUSrcB = 2'b01; e.IRWrite = mr; e.PCWrite = mr; end
            1:  e.ALUSrcB = 2'b11;
            2:  begin e.ALUSrcA = 1; e.ALUSrcB = 2'b10; end
            3:  begin e.MemRead = 1; e.IorD = 1; end
            4:  begin e.RegWrite = 1; e.MemtoReg = 2'b01; end
            5:  begin e.MemWrite = 1; e.IorD = 1; end
            6:  begin e.ALUSrcA = 1; e.ALUOp = 2'b10; e.Shift = (op == 6'b000001); end
            7:  begin e.RegWrite = 1; e.RegDst = 2'b01; end
            8:  begin e.ALUSrcA = 1; e.ALUOp = 2'b01; e.PCWriteCond = 1; e.PCSource = 2'b01; end
            9:  begin e.PCWrite = 1; e.PCSource = 2'b10; end
            10: begin e.PCWrite = 1; e.PCSource = 2'b11; end
            11: begin e.PCWrite = 1; e.PCSource = 2'b10; e.RegWrite = 1;
                      e.RegDst = 2'b10; e.MemtoReg = 2'b10; end
            12: begin e.ALUSrcA = 1; e.ALUSrcB = 2'b10; end
            13: e.RegWrite = 1;
            14: begin e.RegWrite = 1; e.MemtoReg = 2'b11; end
            15: begin e.RegWrite = 1; e.RegDst = 2'b11; e.MemtoReg = 2'b11; e.SwapPhase = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic drive(bit rst, bit mr, out_t e);
        ent_t n;
        @(posedge clk);
        #1;
        reset     = rst;
        mem_ready = mr;
        zero      = 1'($urandom);
        n.rst     = rst;
        n.e       = e;
        exp_q.push_back(n);
    endtask

    task automatic do_reset(int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b1, 1'($urandom), '0);
    endtask

    // Builds the state walk of one instruction, then drives it; abort>0 cuts it short
    // after that many cycles and asserts reset for one cycle.
    task automatic run_instr(bit [5:0] op, int fw, int mw, int abort);
        int sts[$];
        bit mrs[$];
        int path[$];
        int n;
        for (int i = 0; i < fw; i++) begin sts.push_back(0); mrs.push_back(0); end
        sts.push_back(0); mrs.push_back(1);
        case (op)
            6'b100011: path = '{1, 2, 3, 4};
            6'b101011: path = '{1, 2, 5};
            6'b000100: path = '{1, 8};
            6'b000010: path = '{1, 9};
            6'b010000: path = '{1, 10};
            6'b000011: path = '{1, 11};
            6'b001000: path = '{1, 12, 13};
            6'b111111: path = '{1, 14, 15};
            default:   path = '{1, 6, 7};
        endcase
        foreach (path[k]) begin
            if (path[k] == 3 || path[k] == 5) begin
                for (int i = 0; i < mw; i++) begin sts.push_back(path[k]); mrs.push_back(0); end
                sts.push_back(path[k]); mrs.push_back(1);
            end else begin
                sts.push_back(path[k]); mrs.push_back(1'($urandom));
            end
        end
        n = sts.size();
        opCode = op;
        for (int i = 0; i < n; i++) begin
            if (abort > 0 && i == abort) begin
                do_reset(1);
                return;
            end
            drive(1'b0, mrs[i], expect_out(sts[i], mrs[i], op, i == n - 1));
        end
    endtask

    initial begin : monitor
        ent_t  n;
        out_t  act;
        int    exp_cnt = 0;
        forever begin
            @(negedge clk);
            if (mon_stop) break;
            if (exp_q.size() > 0) begin
                n   = exp_q.pop_front();
                act = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                        RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Shift, SwapPhase,
                        instr_done, state};
                tests++;
                if (act !== n.e) begin
                    fails++;
                    $display("FAIL cycle_outputs t=%0t got=%h (state %0d) expected=%h (state %0d)",
                             $time, act, act.state, n.e, n.e.state);
                end
                if (instr_done === 1'b1) seen_done++;
`ifdef CTRL_INSTR_COUNT_EN
                if (!n.rst) begin
                    tests++;
                    if (instr_count !== 32'(exp_cnt)) begin
                        fails++;
                        $display("FAIL instr_count t=%0t got=%0d expected=%0d",
                                 $time, instr_count, exp_cnt);
                    end
                end
`endif
                if (n.rst) exp_cnt = 0;
                else if (n.e.instr_done) begin
                    exp_cnt++;
                    exp_done++;
                end
            end
        end
    end

    initial begin : driver
        bit [5:0] ops[10];
        bit [5:0] op;
        int       sel;
        ops = '{6'h23, 6'h2b, 6'h04, 6'h02, 6'h10, 6'h03, 6'h08, 6'h3f, 6'h01, 6'h00};

        do_reset(2);
        run_instr(6'b000000, 0, 0, 0);
        run_instr(6'b100011, 3, 2, 0);
        run_instr(6'b101011, 0, 0, 0);
        run_instr(6'b000100, 0, 0, 0);
        run_instr(6'b000011, 0, 0, 0);
        run_instr(6'b111111, 0, 0, 0);
        run_instr(6'b000001, 0, 0, 0);
        run_instr(6'b001000, 0, 0, 0);
        run_instr(6'b100011, 0, 5, 4);
        for (int i = 0; i < 9; i++) run_instr(ops[i], i % 3, i % 2, 0);

        for (int i = 0; i < 200; i++) begin
            sel = int'($urandom_range(0, 11));
            op  = (sel < 10) ? ops[sel] : 6'($urandom);
            if ($urandom_range(0, 19) == 0)
                run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(1, 2)));
            else
                run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
        end

        @(negedge clk);
        @(negedge clk);
        mon_stop = 1'b1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d entries left expected=0", exp_q.size());
        end
        tests++;
        if (seen_done != exp_done) begin
            fails++;
            $display("FAIL done_pulses got=%0d expected=%0d", seen_done, exp_done);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
